// File: rtl/key_encoder_8to3_pkg.sv
// Shared types and helpers for the key encoder: FSM state, default widths,
// and the priority-encode / multi-key detection functions.
package key_pkg;

    localparam int KEY_IN_W       = 8;
    localparam int KEY_CODE_W     = 3;
    // Helpers work on a fixed wide vector; callers zero-extend and truncate.
    localparam int KEY_MAX_W      = 32;
    localparam int KEY_MAX_CODE_W = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } key_state_e;

    function automatic logic [KEY_MAX_CODE_W-1:0] prio_enc(input logic [KEY_MAX_W-1:0] v);
        logic [KEY_MAX_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_MAX_W; i++) begin
            if (v[i]) idx = i[KEY_MAX_CODE_W-1:0];
        end
        return idx;
    endfunction

    function automatic logic popcnt_gt1(input logic [KEY_MAX_W-1:0] v);
        return (v & (v - KEY_MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/key_encoder_8to3_if.sv
// Key-line / code handshake bundle between the board inputs, the encoder and
// the consuming control logic.
interface key_encoder_8to3_if #(
    parameter int IN_W   = 8,
    parameter int CODE_W = 3
);
    logic [IN_W-1:0]   d;
    logic              en;
    logic              ack;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              multi;
    logic              overrun;

    modport master (
        output d, en, ack,
        input  code, valid, multi, overrun
    );

    modport slave (
        input  d, en, ack,
        output code, valid, multi, overrun
    );
endinterface

// File: rtl/key_encoder_8to3_debounce.sv
// Two-flop synchronizer plus stability counter: deb only takes a new vector
// after DEBOUNCE_CYCLES consecutive identical synchronized samples.
module key_debounce #(
    parameter int IN_W            = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [IN_W-1:0] d,
    output logic [IN_W-1:0] deb
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IN_W-1:0]  s1_q, s2_q;
    logic [IN_W-1:0]  deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The synchronizer keeps running while disabled so a held key is seen at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    // A "matching cycle" is one where s2 will not change at this edge.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (!en) begin
            cnt_d = '0;
            deb_d = '0;
        end else if (s1_q != s2_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            deb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/key_encoder_8to3.sv
// Registered 8-to-3 key encoder: debounced press detection, priority encode,
// and a valid/ack output holding register with sticky overrun.
module key_encoder_8to3
    import key_pkg::*;
#(
    parameter int IN_W            = KEY_IN_W,
    parameter int CODE_W          = KEY_CODE_W,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    key_encoder_8to3_if.slave bus
);
    logic [IN_W-1:0]   deb;
    logic [CODE_W-1:0] enc_code;
    logic              enc_multi;
    logic              event_w;

    key_state_e        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              multi_q, multi_d;
    logic              overrun_q, overrun_d;

    key_debounce #(
        .IN_W            (IN_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .d     (bus.d),
        .deb   (deb)
    );

    assign enc_code  = CODE_W'(prio_enc(KEY_MAX_W'(deb)));
    assign enc_multi = popcnt_gt1(KEY_MAX_W'(deb));

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = valid_q;
        multi_d   = multi_q;
        overrun_d = overrun_q;
        event_w   = 1'b0;
        if (!bus.en) begin
            state_d   = IDLE;
            code_d    = '0;
            valid_d   = 1'b0;
            multi_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (deb != '0) begin
                        state_d = PRESSED;
                        event_w = 1'b1;
                    end
                end
                PRESSED: begin
                    if (deb == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // An ack in the event cycle frees the register for the new code.
            if (event_w) begin
                if (!valid_q || bus.ack) begin
                    code_d    = enc_code;
                    multi_d   = enc_multi;
                    valid_d   = 1'b1;
                    overrun_d = 1'b0;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (valid_q && bus.ack) begin
                valid_d   = 1'b0;
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.multi   = multi_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_key_encoder_8to3.sv
// Directed bench for key_encoder_8to3 with DEBOUNCE_CYCLES=4: press latency,
// glitch rejection, multi-key, overrun, ack-on-event, enable clear and reset.
module tb_key_encoder_8to3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    key_encoder_8to3_if #(.IN_W(8), .CODE_W(3)) bus ();

    key_encoder_8to3 #(
        .IN_W            (8),
        .CODE_W          (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [2:0] c,
                              input logic m, input logic o);
        check_val({tag, ".valid"},   32'(bus.valid),   32'(v));
        check_val({tag, ".code"},    32'(bus.code),    32'(c));
        check_val({tag, ".multi"},   32'(bus.multi),   32'(m));
        check_val({tag, ".overrun"}, 32'(bus.overrun), 32'(o));
    endtask

    task automatic pulse_ack;
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
    endtask

    initial begin
        logic any_out;
        rst_n  = 1'b0;
        bus.d  = '0;
        bus.en = 1'b1;
        bus.ack = 1'b0;
        tick(3);
        check_outs("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle 50 cycles with no keys
        any_out = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            any_out = any_out | bus.valid | (|bus.code) | bus.multi | bus.overrun;
        end
        check_val("idle50.any_out", 32'(any_out), 32'd0);

        // Single key 5: event visible after edge E+6, not before
        bus.d = 8'h20;
        tick(6);
        check_val("press20.early_valid", 32'(bus.valid), 32'd0);
        tick(1);
        check_outs("press20", 1'b1, 3'd5, 1'b0, 1'b0);
        pulse_ack();
        check_outs("ack20", 1'b0, 3'd5, 1'b0, 1'b0);

        // Three-cycle glitch is rejected
        bus.d = 8'h00;
        tick(10);
        bus.d = 8'h01;
        tick(3);
        bus.d = 8'h00;
        tick(12);
        check_val("glitch.deb", 32'(dut.deb), 32'd0);
        check_val("glitch.valid", 32'(bus.valid), 32'd0);
        bus.d = 8'h01;
        tick(7);
        check_outs("press01", 1'b1, 3'd0, 1'b0, 1'b0);
        pulse_ack();
        check_val("ack01.valid", 32'(bus.valid), 32'd0);

        // Multi-key, then nonzero-to-nonzero change gives no event
        bus.d = 8'h00;
        tick(10);
        bus.d = 8'h12;
        tick(7);
        check_outs("press12", 1'b1, 3'd4, 1'b1, 1'b0);
        pulse_ack();
        bus.d = 8'h02;
        tick(12);
        check_val("change02.valid", 32'(bus.valid), 32'd0);

        // Second event without ack: first code held, overrun set
        bus.d = 8'h00;
        tick(10);
        bus.d = 8'h01;
        tick(7);
        check_outs("ovr.first", 1'b1, 3'd0, 1'b0, 1'b0);
        bus.d = 8'h00;
        tick(10);
        bus.d = 8'h80;
        tick(7);
        check_outs("ovr.second", 1'b1, 3'd0, 1'b0, 1'b1);

        // Ack on the edge a new event fires: valid stays, new code, overrun cleared
        bus.d = 8'h00;
        tick(10);
        bus.d = 8'h80;
        tick(6);
        pulse_ack();
        check_outs("ackevt", 1'b1, 3'd7, 1'b0, 1'b0);
        pulse_ack();
        check_val("ackevt.clear", 32'(bus.valid), 32'd0);

        // Enable drop clears; held key re-fires 5 edges after en rises
        bus.d = 8'h00;
        tick(10);
        bus.d = 8'h08;
        tick(7);
        check_outs("press08", 1'b1, 3'd3, 1'b0, 1'b0);
        bus.en = 1'b0;
        tick(1);
        bus.en = 1'b1;
        check_outs("en_low", 1'b0, 3'd0, 1'b0, 1'b0);
        tick(4);
        check_val("en_rise.early_valid", 32'(bus.valid), 32'd0);
        tick(1);
        check_outs("en_rise", 1'b1, 3'd3, 1'b0, 1'b0);

        // Reset mid-debounce with valid pending discards everything
        bus.d = 8'h04;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check_outs("rst_mid", 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(6);
        check_val("post_rst.early_valid", 32'(bus.valid), 32'd0);
        tick(1);
        check_outs("post_rst", 1'b1, 3'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
